fixed_point_multiplier: RTL and testbench
=========================================

// Module: fixed_point_multiplier
// PURPOSE
//   Pipelined signed fixed-point multiplier for the CNN datapath (conv/FC MAC stages).
//   Multiplies two two's-complement QI.F operands and returns a result in the same QI.F format.
//   Default format is Q2.30: 32 bits, 30 fraction bits, 1.0 = 0x40000000, range [-2.0, 2.0).
//   Pipeline depth is fixed. There is no backpressure.
// PARAMETERS
//   WIDTH      32  total operand/result width in bits (signed), >= 4
//   FRAC_SIZE  30  fraction bits, 1 <= FRAC_SIZE <= WIDTH-2
// PORTS
//   clk       in   1      rising-edge clock, sole clock
//   rst       in   1      synchronous, active-high reset
//   in_valid  in   1      data0/data1 are valid this cycle
//   data0     in   WIDTH  signed multiplicand, QI.F
//   data1     in   WIDTH  signed multiplier, QI.F
//   out_valid out  1      prod/overflow are valid this cycle
//   prod      out  WIDTH  signed product, QI.F
//   overflow  out  1      true product was outside the representable range
// BEHAVIOUR
//   - Reset: on a clk edge with rst=1, all pipeline valid bits, out_valid, prod and overflow clear to 0.
//     Reset has priority over in_valid. Any in-flight operation is discarded, never emitted.
//   - Latency: exactly 2 cycles. Inputs sampled at edge N produce outputs registered at edge N+2.
//     Throughput is 1 operation per cycle.
//   - Stage 1: full = $signed(data0) * $signed(data1), 2*WIDTH bits, Q(2I).(2F).
//     Stage 1 also registers in_valid.
//   - Stage 2: scaled = full >>> FRAC_SIZE (arithmetic shift; truncation toward -inf, no rounding).
//     Then apply the range check and the result selection below.
//   - Range check: overflow=1 when scaled is outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
//     Equivalently, bits full[2*WIDTH-1 : FRAC_SIZE+WIDTH-1] are not all equal.
//   - Default result selection: prod = full[FRAC_SIZE+WIDTH-1 : FRAC_SIZE] (wrap-around).
//   - Bubbles: when out_valid=0, prod and overflow hold their previous values.
//     Consumers must qualify prod with out_valid.
//   - Edge case: -2.0 * -2.0 (both operands 0x80000000) is out of range; overflow=1.
//   - Purely synchronous design: no latches, no combinational path from inputs to outputs.
// CONFIGURATION
//   FXP_MUL_SATURATE_EN
//     defined:   on overflow, prod clamps to 2^(WIDTH-1)-1 (positive) or -2^(WIDTH-1) (negative).
//                Overflow sign = sign of full.
//     undefined: prod wraps (bit slice above).
//     In both builds the overflow output behaves identically.
// TESTING (Q2.30 defaults)
//   1. data0=0xF0000000 (-0.25), data1=0x20000000 (0.5), in_valid=1
//        -> 2 cycles later: out_valid=1, prod=0xF8000000 (-0.125), overflow=0.
//   2. data0=0xE0000000 (-0.5), data1=0xE0000000 (-0.5)
//        -> prod=0x10000000 (0.25), overflow=0.
//   3. data0=data1=0x60000000 (1.5)
//        -> overflow=1; prod=0x90000000 (wrap build), 0x7FFFFFFF (FXP_MUL_SATURATE_EN build).
//   4. Back-to-back tests 1,2,3 on consecutive cycles
//        -> results on 3 consecutive cycles, in order; then out_valid=0 when in_valid drops.
//   5. rst=1 one cycle after issuing test 1
//        -> out_valid=0, prod=0, overflow=0; the test 1 result never appears.
//   6. data0=0x00000001, data1=0xFFFFFFFF (smallest +/- LSBs)
//        -> prod=0xFFFFFFFF (truncation toward -inf), overflow=0.

Source files
------------

// File: rtl/fxp_mul_if.sv
// Operand/result bundle for fixed_point_multiplier.
// The master drives operands and consumes results; the slave is the multiplier.
interface fxp_mul_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic             out_valid;
  logic [WIDTH-1:0] prod;
  logic             overflow;

  modport master (
    output in_valid, data0, data1,
    input  out_valid, prod, overflow
  );

  modport slave (
    input  in_valid, data0, data1,
    output out_valid, prod, overflow
  );
endinterface

// File: rtl/fixed_point_multiplier.sv
// Pipelined signed QI.F multiplier, result in the same QI.F format.
// Pipeline: operand register -> full-product register -> result register,
// so operands sampled at edge N appear on the outputs registered at edge N+2.
// Overflow flags a true product outside the representable range.
// Build option FXP_MUL_SATURATE_EN: when defined, overflowing results clamp
// to the most positive/negative value; otherwise they wrap.
module fixed_point_multiplier #(
  parameter int WIDTH     = 32,
  parameter int FRAC_SIZE = 30
) (
  input  logic        clk,
  input  logic        rst,
  fxp_mul_if.slave    bus
);

  // Only product bits at or above the binary point are ever needed, so the
  // product register keeps bits [2*WIDTH-1 : FRAC_SIZE] of the full product.
  localparam int HW = 2 * WIDTH - FRAC_SIZE;
  // Bits that must all agree with the result sign for the value to fit.
  localparam int CW = WIDTH - FRAC_SIZE + 1;

  logic signed [WIDTH-1:0]   a_q, b_q;
  logic                      v0_q, v1_q;
  logic signed [2*WIDTH-1:0] a_ext, b_ext, full;
  logic signed [HW-1:0]      full_hi_d, full_hi_q;
  logic        [CW-1:0]      check_bits;
  logic        [WIDTH-1:0]   prod_d, prod_q;
  logic                      overflow_d, overflow_q;
  logic                      out_valid_q;

  // Operand capture; valid is reset, operand data is not.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, regardless of block order.
    if (rst) begin
      v0_q <= 1'b0;
    end else begin
      v0_q <= bus.in_valid;
    end
    // NOTE: datapath registers carry no reset; the valid bits alone decide
    // whether their contents are meaningful, which keeps reset fan-out small.
    a_q <= bus.data0;
    b_q <= bus.data1;
  end

  // Full signed product, aligned down to the binary point (floor, no rounding).
  always_comb begin
    // NOTE: every combinational output gets an unconditional assignment first,
    // so no path can leave a value unassigned and infer a latch.
    a_ext     = {{WIDTH{a_q[WIDTH-1]}}, a_q};
    b_ext     = {{WIDTH{b_q[WIDTH-1]}}, b_q};
    full      = a_ext * b_ext;
    full_hi_d = HW'(full >>> FRAC_SIZE);
  end

  // Product stage register.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
    end else begin
      v1_q <= v0_q;
    end
    full_hi_q <= full_hi_d;
  end

  // Range check and result selection (wrap or clamp).
  always_comb begin
    check_bits = full_hi_q[HW-1:WIDTH-1];
    overflow_d = !((&check_bits) || !(|check_bits));
    prod_d     = full_hi_q[WIDTH-1:0];
`ifdef FXP_MUL_SATURATE_EN
    if (overflow_d) begin
      prod_d = full_hi_q[HW-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                               : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // Result register; prod/overflow hold through bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      prod_q      <= '0;
      overflow_q  <= 1'b0;
    end else begin
      out_valid_q <= v1_q;
      if (v1_q) begin
        prod_q     <= prod_d;
        overflow_q <= overflow_d;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.prod      = prod_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_fixed_point_multiplier.sv
// Self-checking bench for fixed_point_multiplier (Q2.30 defaults).
// Honours FXP_MUL_SATURATE_EN so it can be built against either variant.
module tb_fixed_point_multiplier;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic rst_edge = 1'b0;

  fxp_mul_if #(.WIDTH(32)) bus ();

  fixed_point_multiplier #(.WIDTH(32), .FRAC_SIZE(30)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [31:0] p;
    logic        o;
  } vec_t;

  typedef struct {
    int          due;
    string       name;
    logic [31:0] p;
    logic        o;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last_prod = '0;
  logic        last_ovf  = 1'b0;

`ifdef FXP_MUL_SATURATE_EN
  localparam logic [31:0] EXP_1P5SQ = 32'h7FFF_FFFF;
  localparam logic [31:0] EXP_M2SQ  = 32'h7FFF_FFFF;
  localparam bit          SAT       = 1'b1;
`else
  localparam logic [31:0] EXP_1P5SQ = 32'h9000_0000;
  localparam logic [31:0] EXP_M2SQ  = 32'h0000_0000;
  localparam bit          SAT       = 1'b0;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: real-valued semantics with 64-bit integers.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] p, output logic o);
    longint fa, fb, full, sc;
    fa   = longint'($signed(a));
    fb   = longint'($signed(b));
    full = fa * fb;
    sc   = full >>> 30;
    o    = (sc > 64'sd2147483647) || (sc < -64'sd2147483648);
    p    = sc[31:0];
    if (SAT && o) p = (full < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
  endfunction

  always @(posedge clk) begin
    cyc++;
    rst_edge = rst;
  end

  // Output monitor: every cycle checks valid, data, and hold behaviour.
  always @(negedge clk) begin
    exp_t e;
    if (rst_edge) begin
      check("rst_out_valid", 64'(bus.out_valid), 64'(0));
      check("rst_prod", 64'(bus.prod), 64'(0));
      check("rst_overflow", 64'(bus.overflow), 64'(0));
      sb.delete();
      last_prod = '0;
      last_ovf  = 1'b0;
    end else if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check({e.name, "_valid"}, 64'(bus.out_valid), 64'(1));
      check({e.name, "_prod"}, 64'(bus.prod), 64'(e.p));
      check({e.name, "_ovf"}, 64'(bus.overflow), 64'(e.o));
      last_prod = e.p;
      last_ovf  = e.o;
    end else begin
      check("idle_valid", 64'(bus.out_valid), 64'(0));
      check("idle_prod_hold", 64'(bus.prod), 64'(last_prod));
      check("idle_ovf_hold", 64'(bus.overflow), 64'(last_ovf));
    end
  end

  task automatic issue(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, input logic o);
    exp_t e;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.data0    = a;
    bus.data1    = b;
    e.due  = cyc + 3;
    e.name = name;
    e.p    = p;
    e.o    = o;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.data0    = $urandom;
      bus.data1    = $urandom;
    end
  endtask

  vec_t vecs[9];

  initial begin
    logic [31:0] a, b, p;
    logic        o;
    int          wait_cnt;

    vecs[0] = '{"t1_neg_quarter_x_half", 32'hF000_0000, 32'h2000_0000, 32'hF800_0000, 1'b0};
    vecs[1] = '{"t2_neg_half_sq",        32'hE000_0000, 32'hE000_0000, 32'h1000_0000, 1'b0};
    vecs[2] = '{"t3_one_five_sq",        32'h6000_0000, 32'h6000_0000, EXP_1P5SQ,     1'b1};
    vecs[3] = '{"t6_lsb_trunc",          32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    vecs[4] = '{"neg_two_sq",            32'h8000_0000, 32'h8000_0000, EXP_M2SQ,      1'b1};
    vecs[5] = '{"one_sq",                32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 1'b0};
    vecs[6] = '{"neg_two_x_one",         32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 1'b0};
    vecs[7] = '{"max_x_one",             32'h7FFF_FFFF, 32'h4000_0000, 32'h7FFF_FFFF, 1'b0};
    vecs[8] = '{"neg_two_x_neg_half",    32'h8000_0000, 32'hE000_0000, 32'h4000_0000, 1'b0};

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.data0    = '0;
    bus.data1    = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // Directed table, issued back to back.
    for (int i = 0; i < 9; i++) issue(vecs[i].name, vecs[i].d0, vecs[i].d1, vecs[i].p, vecs[i].o);
    idle(4);

    // Three consecutive operations, then in_valid drops.
    for (int i = 0; i < 3; i++) issue({"b2b_", vecs[i].name}, vecs[i].d0, vecs[i].d1, vecs[i].p, vecs[i].o);
    idle(5);

    // Reset one cycle after issuing: result must be discarded.
    issue("flushed_t1", vecs[0].d0, vecs[0].d1, vecs[0].p, vecs[0].o);
    @(posedge clk);
    #1;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(5);

    // Reset wins over a simultaneous in_valid.
    @(posedge clk);
    #1;
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.data0    = vecs[2].d0;
    bus.data1    = vecs[2].d1;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    idle(5);

    // Randomized traffic with bubbles, against the arithmetic model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle($urandom_range(1, 3));
      end else begin
        case ($urandom_range(0, 3))
          0: begin a = $urandom; b = $urandom; end
          1: begin a = 32'($signed($urandom_range(0, 64)) - 32); b = $urandom; end
          2: begin a = {$urandom_range(0, 1) ? 2'b10 : 2'b01, 30'($urandom)}; b = {$urandom_range(0, 1) ? 2'b10 : 2'b01, 30'($urandom)}; end
          default: begin a = $urandom & 32'hC000_FFFF; b = $urandom | 32'h3000_0000; end
        endcase
        model(a, b, p, o);
        issue("rand", a, b, p, o);
      end
    end
    idle(1);

    wait_cnt = 0;
    while (sb.size() > 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    @(posedge clk);
    #1;
    check("drain_pending", 64'(sb.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
